// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, issues single-cycle IMEM requests,
// holds the returned word for decode, redirects on branches and latches faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [19:0] IMEM_HI  = 20'h01000,
  parameter int unsigned TIMEOUT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        instrfetch,
  output logic [31:0] addr_imem,
  input  logic [31:0] instr,
  input  logic        instr_fetched,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_WINDOW   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  localparam int unsigned          TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]        TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]        TCNT_ZERO  = '0;
  localparam logic [TW-1:0]        TCNT_ONE   = TW'(1);

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic          flush_r, flush_s;
  logic [TW-1:0] tcnt_r, tcnt_s;
  logic [31:0]   instr_out_r, instr_out_s;
  logic [31:0]   pc_out_r, pc_out_s;
  logic          instr_valid_r, instr_valid_s;
  logic          fetch_fault_r, fetch_fault_s;
  logic [1:0]    fault_cause_r, fault_cause_s;

  logic          misaligned_s;
  logic          out_of_window_s;
  logic          issue_s;

  // Address pre-check: a bad PC must never reach the memory as a request.
  always_comb begin
    misaligned_s    = (pc_r[1:0] != 2'b00);
    out_of_window_s = (pc_r[31:12] != IMEM_HI);
    issue_s         = (state_r == ST_REQ) && !misaligned_s && !out_of_window_s;
  end

  assign instrfetch  = issue_s && rst;
  assign addr_imem   = pc_r;
  assign instr_out   = instr_out_r;
  assign pc_out      = pc_out_r;
  assign instr_valid = instr_valid_r;
  assign fetch_fault = fetch_fault_r;
  assign fault_cause = fault_cause_r;

  // Next-state and datapath update for the fetch FSM.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    flush_s       = flush_r;
    tcnt_s        = tcnt_r;
    instr_out_s   = instr_out_r;
    pc_out_s      = pc_out_r;
    instr_valid_s = instr_valid_r;
    fetch_fault_s = fetch_fault_r;
    fault_cause_s = fault_cause_r;

    case (state_r)
      ST_REQ: begin
        // A bad PC faults before any redirect; no request was issued.
        if (misaligned_s) begin
          state_s       = ST_FAULT;
          fetch_fault_s = 1'b1;
          fault_cause_s = CAUSE_MISALIGN;
          instr_valid_s = 1'b0;
        end else if (out_of_window_s) begin
          state_s       = ST_FAULT;
          fetch_fault_s = 1'b1;
          fault_cause_s = CAUSE_WINDOW;
          instr_valid_s = 1'b0;
        end else begin
          state_s = ST_WAIT;
          tcnt_s  = TCNT_ZERO;
          if (branch_taken) begin
            pc_s    = branch_target;
            flush_s = 1'b1;
          end else begin
            flush_s = flush_r;
          end
        end
      end

      ST_WAIT: begin
        if (branch_taken) begin
          pc_s = branch_target;
          if (instr_fetched) begin
            // Outstanding response lands together with the redirect: drop it.
            flush_s = 1'b0;
            state_s = ST_REQ;
          end else if (tcnt_r == TCNT_LAST) begin
            state_s       = ST_FAULT;
            fetch_fault_s = 1'b1;
            fault_cause_s = CAUSE_TIMEOUT;
          end else begin
            flush_s = 1'b1;
            tcnt_s  = tcnt_r + TCNT_ONE;
          end
        end else if (instr_fetched) begin
          if (flush_r) begin
            flush_s = 1'b0;
            state_s = ST_REQ;
          end else begin
            instr_out_s   = instr;
            pc_out_s      = pc_r;
            instr_valid_s = 1'b1;
            state_s       = ST_HOLD;
          end
        end else if (tcnt_r == TCNT_LAST) begin
          state_s       = ST_FAULT;
          fetch_fault_s = 1'b1;
          fault_cause_s = CAUSE_TIMEOUT;
        end else begin
          tcnt_s = tcnt_r + TCNT_ONE;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          pc_s          = branch_target;
          instr_valid_s = 1'b0;
          state_s       = ST_REQ;
        end else if (!stall) begin
          pc_s          = pc_r + 32'd4;
          instr_valid_s = 1'b0;
          state_s       = ST_REQ;
        end else begin
          state_s       = ST_HOLD;
          instr_valid_s = instr_valid_r;
        end
      end

      ST_FAULT: begin
        state_s       = ST_FAULT;
        instr_valid_s = 1'b0;
      end

      default: begin
        state_s       = ST_FAULT;
        instr_valid_s = 1'b0;
        fetch_fault_s = 1'b1;
        fault_cause_s = fault_cause_r;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      flush_r       <= 1'b0;
      tcnt_r        <= TCNT_ZERO;
      instr_out_r   <= 32'h0000_0000;
      pc_out_r      <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      fetch_fault_r <= 1'b0;
      fault_cause_r <= CAUSE_NONE;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      flush_r       <= flush_s;
      tcnt_r        <= tcnt_s;
      instr_out_r   <= instr_out_s;
      pc_out_r      <= pc_out_s;
      instr_valid_r <= instr_valid_s;
      fetch_fault_r <= fetch_fault_s;
      fault_cause_r <= fault_cause_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small IMEM responder of selectable latency.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instrfetch;
  logic [31:0] addr_imem;
  logic [31:0] instr = 32'h0000_0000;
  logic        instr_fetched = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0000_0000;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  logic        resp_en = 1'b1;
  logic        lat2 = 1'b0;
  logic        inject = 1'b0;
  logic        req_d1 = 1'b0;
  logic [31:0] addr_d1 = 32'h0000_0000;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (RESET_PC),
    .IMEM_HI  (20'h01000),
    .TIMEOUT  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instrfetch    (instrfetch),
    .addr_imem     (addr_imem),
    .instr         (instr),
    .instr_fetched (instr_fetched),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .fetch_fault   (fetch_fault),
    .fault_cause   (fault_cause)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // IMEM responder: pulses one or two cycles after a sampled request.
  always @(posedge clk) begin
    req_d1        <= instrfetch;
    addr_d1       <= addr_imem;
    instr_fetched <= inject || (resp_en && (lat2 ? req_d1 : instrfetch));
    instr         <= lat2 ? imem_word(addr_d1) : imem_word(addr_imem);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_valid", instr_valid, 32'd0);
    check_val("rst_fault", fetch_fault, 32'd0);
    check_val("rst_cause", fault_cause, 32'd0);
    check_val("rst_instr_out", instr_out, 32'd0);
    check_val("rst_pc_out", pc_out, 32'd0);
    check_val("rst_fetch_gated", instrfetch, 32'd0);
    check_val("rst_addr", addr_imem, RESET_PC);
    rst = 1'b1;
    #1;

    // Free run, one instruction every three cycles
    for (int i = 0; i < 3; i++) begin
      a = RESET_PC + 32'(4 * i);
      check_val("run_fetch", instrfetch, 32'd1);
      check_val("run_addr", addr_imem, a);
      @(negedge clk);
      check_val("run_wait_nofetch", instrfetch, 32'd0);
      check_val("run_wait_invalid", instr_valid, 32'd0);
      @(negedge clk);
      check_val("run_valid", instr_valid, 32'd1);
      check_val("run_instr", instr_out, imem_word(a));
      check_val("run_pc", pc_out, a);
      @(negedge clk);
    end

    // Stall in HOLD for five cycles
    check_val("stall_req_addr", addr_imem, 32'h0100_000C);
    @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_val("stall_valid", instr_valid, 32'd1);
      check_val("stall_instr", instr_out, imem_word(32'h0100_000C));
      check_val("stall_pc", pc_out, 32'h0100_000C);
      check_val("stall_nofetch", instrfetch, 32'd0);
      @(negedge clk);
    end
    stall = 1'b0;
    check_val("stall_still_valid", instr_valid, 32'd1);
    @(negedge clk);
    check_val("release_fetch", instrfetch, 32'd1);
    check_val("release_addr", addr_imem, 32'h0100_0010);

    // Redirect during WAIT with a two-cycle responder: stale word flushed
    lat2 = 1'b1;
    @(negedge clk);
    branch_taken  = 1'b1;
    branch_target = 32'h0100_0100;
    @(negedge clk);
    branch_taken = 1'b0;
    check_val("flush_wait_invalid", instr_valid, 32'd0);
    check_val("flush_wait_nofetch", instrfetch, 32'd0);
    @(negedge clk);
    lat2 = 1'b0;
    check_val("flush_refetch", instrfetch, 32'd1);
    check_val("flush_addr", addr_imem, 32'h0100_0100);
    check_val("flush_no_valid", instr_valid, 32'd0);
    @(negedge clk);
    check_val("flush_wait2_invalid", instr_valid, 32'd0);
    @(negedge clk);
    check_val("target_valid", instr_valid, 32'd1);
    check_val("target_instr", instr_out, imem_word(32'h0100_0100));
    check_val("target_pc", pc_out, 32'h0100_0100);

    // Redirect from HOLD to a misaligned target
    branch_taken  = 1'b1;
    branch_target = 32'h0100_0102;
    @(negedge clk);
    branch_taken = 1'b0;
    check_val("mis_req_nofetch", instrfetch, 32'd0);
    check_val("mis_req_invalid", instr_valid, 32'd0);
    check_val("mis_req_addr", addr_imem, 32'h0100_0102);
    check_val("mis_req_nofault_yet", fetch_fault, 32'd0);
    @(negedge clk);
    check_val("mis_fault", fetch_fault, 32'd1);
    check_val("mis_cause", fault_cause, 32'd1);
    check_val("mis_nofetch", instrfetch, 32'd0);
    branch_taken  = 1'b1;
    branch_target = RESET_PC;
    repeat (2) @(negedge clk);
    branch_taken = 1'b0;
    check_val("fault_sticky", fetch_fault, 32'd1);
    check_val("fault_cause_held", fault_cause, 32'd1);
    check_val("fault_branch_ignored", addr_imem, 32'h0100_0102);
    check_val("fault_nofetch", instrfetch, 32'd0);

    // Redirect in REQ to an out-of-window target
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0200_0000;
    #1;
    check_val("win_req_fetch", instrfetch, 32'd1);
    @(negedge clk);
    branch_taken = 1'b0;
    check_val("win_wait_nofetch", instrfetch, 32'd0);
    check_val("win_wait_addr", addr_imem, 32'h0200_0000);
    @(negedge clk);
    check_val("win_req_nofetch", instrfetch, 32'd0);
    check_val("win_req_invalid", instr_valid, 32'd0);
    @(negedge clk);
    check_val("win_fault", fetch_fault, 32'd1);
    check_val("win_cause", fault_cause, 32'd2);

    // Silent responder: timeout after eight WAIT cycles
    rst     = 1'b0;
    resp_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("to_fetch", instrfetch, 32'd1);
    repeat (8) @(negedge clk);
    check_val("to_not_yet", fetch_fault, 32'd0);
    @(negedge clk);
    check_val("to_fault", fetch_fault, 32'd1);
    check_val("to_cause", fault_cause, 32'd3);
    check_val("to_invalid", instr_valid, 32'd0);

    // Reset while in WAIT; late pulse lands in REQ and is ignored
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rw_fetch", instrfetch, 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    inject = 1'b1;
    @(negedge clk);
    rst     = 1'b1;
    inject  = 1'b0;
    resp_en = 1'b1;
    #1;
    check_val("rw_addr", addr_imem, RESET_PC);
    check_val("rw_invalid", instr_valid, 32'd0);
    check_val("rw_fault_clr", fetch_fault, 32'd0);
    check_val("rw_cause_clr", fault_cause, 32'd0);
    check_val("rw_refetch", instrfetch, 32'd1);
    @(negedge clk);
    check_val("rw_wait_invalid", instr_valid, 32'd0);
    @(negedge clk);
    check_val("rw_valid", instr_valid, 32'd1);
    check_val("rw_instr", instr_out, imem_word(RESET_PC));
    check_val("rw_pc", pc_out, RESET_PC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
